id_reg_file: RTL and testbench
==============================

// Module: id_reg_file
// PURPOSE
//   Integer general-purpose register file for the instruction-decode (ID) stage.
//   Holds 32 x 32-bit architectural registers, with x0 hardwired to zero.
//   Two combinational read ports supply decode operands; one synchronous write port
//   takes write-back results. Reads are write-first: same-cycle write data is
//   forwarded to a reader of the same register.
// PARAMETERS
//   XLEN       32  data width of each register and of the data ports (`COMMON_WIDTH)
//   REG_NUM    32  number of architectural registers (`REG_NUM)
//   REG_AW     5   register index width, log2(REG_NUM) (`REG_NUM_WIDTH)
// PORTS
//   clk         in   1       single clock; all state updates on rising edge
//   rst         in   1       synchronous reset, active-high
//   rs1         in   REG_AW  read port 1 register index
//   rs2         in   REG_AW  read port 2 register index
//   reg_write   in   REG_AW  write-back destination index; 0 = no write
//   data_write  in   XLEN    write-back data
//   src1        out  XLEN    read port 1 data (combinational)
//   src2        out  XLEN    read port 2 data (combinational)
// BEHAVIOUR
//   - Storage: array regs[0:REG_NUM-1] of XLEN bits, under exactly that name
//     (benches peek DUT.regs[i]).
//   - Reset: on a rising clk with rst=1, every regs[i] <= 0. Writes are ignored
//     in that cycle.
//   - While rst=1, src1 = src2 = 0, independent of indices and bypass.
//   - Write: on a rising clk with rst=0 and reg_write != 0,
//     regs[reg_write] <= data_write. There is no separate enable; index 0 means
//     "no write".
//   - x0: regs[0] is never written and always reads 0, even if reg_write = 0
//     and data_write != 0.
//   - Read, per port n (rs = rs1 / rs2), all combinational, zero-cycle latency:
//       rst = 1                                  -> 0
//       rs = 0                                   -> 0
//       rs == reg_write (rs != 0)                -> data_write (write-first bypass)
//       otherwise                                -> regs[rs]
//   - Both ports are independent: they may address the same register, and both
//     bypass simultaneously.
//   - Reset mid-operation: a write presented in the same cycle as rst is dropped.
//     After rst falls, all registers read 0 until written.
//   - No X propagation: every output is fully defined for any defined input.
//   - Only state is the register array; no FSM, no handshake.
// TESTING
//   1. Reset: rst=1 for 1+ edges, then rst=0. All regs[0..31] == 0;
//      src1 = src2 = 0 for every index.
//   2. Write/read: rs1=1, reg_write=1, data_write=1.
//      src1 == 1 before the edge (bypass); after the edge, regs[1] == 1.
//      Then reg_write=0: src1 is still 1 (from storage).
//   3. x0: reg_write=0, data_write=32'hDEADBEEF, clock edge; rs1=0 -> src1 == 0;
//      regs[0] == 0.
//   4. Dual read: write x5=32'h1234 and x31=32'hFFFFFFFF; set rs1=5, rs2=31
//      -> src1 == 32'h1234, src2 == 32'hFFFFFFFF. Set rs1 = rs2 = 5 -> both
//      32'h1234.
//   5. Bypass vs stale: x7=10 stored; drive reg_write=7, data_write=20, rs1=7,
//      rs2=7 -> both 20 pre-edge, regs[7] == 20 post-edge.
//   6. Reset mid-op: rst=1 together with reg_write=3, data_write=9 -> regs[3]
//      stays 0, src outputs 0; after rst=0 all previously written regs read 0.

Source files
------------

// File: rtl/id_reg_file.sv
// id_reg_file: integer register file for the instruction-decode stage.
//   32 x XLEN architectural registers, x0 hardwired to zero. Two combinational
//   read ports, one synchronous write port. Reads are write-first: data being
//   written this cycle is forwarded to any port reading that register.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous reset, active high; clears every register and
//                forces both read ports to zero while asserted
//   rs1, rs2   - read port indices
//   reg_write  - write-back destination index, 0 means no write
//   data_write - write-back data
//   src1, src2 - read port data (combinational)

// One read port: selects between zero, the write-back bypass and storage.
module id_reg_file_rdport #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              rst,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] reg_write,
  input  logic [XLEN-1:0]   data_write,
  input  logic [XLEN-1:0]   stored,
  output logic [XLEN-1:0]   src
);
  always_comb begin
    src = stored;
    // Priority matters: reset beats x0, x0 beats bypass (reg_write==0 is
    // "no write", so it must never forward onto a read of x0).
    if (rst)                   src = '0;
    else if (rs == '0)         src = '0;
    else if (rs == reg_write)  src = data_write;
  end
endmodule

module id_reg_file #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] reg_write,
  input  logic [XLEN-1:0]   data_write,
  output logic [XLEN-1:0]   src1,
  output logic [XLEN-1:0]   src2
);
  localparam int NUM_RD = 2;

  logic [XLEN-1:0] regs [0:REG_NUM-1];

  logic [NUM_RD-1:0][REG_AW-1:0] rs_idx;
  logic [NUM_RD-1:0][XLEN-1:0]   src_bus;

  assign rs_idx = {rs2, rs1};
  assign src1   = src_bus[0];
  assign src2   = src_bus[1];

  // Write port. x0 is cleared by reset and never targeted (index 0 means
  // "no write"), so it stays zero without a dedicated guard on the storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (reg_write != '0) begin
      regs[reg_write] <= data_write;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    id_reg_file_rdport #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rd (
      .rst        (rst),
      .rs         (rs_idx[p]),
      .reg_write  (reg_write),
      .data_write (data_write),
      .stored     (regs[rs_idx[p]]),
      .src        (src_bus[p])
    );
  end
endmodule

// File: tb/tb_id_reg_file.sv
// Self-checking bench for id_reg_file. A reference model of the register
// array produces the expected read data when stimulus is driven; those values
// are queued and popped when the outputs are sampled before the next edge.
// Storage is also compared against the model after writes.
module tb_id_reg_file;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, reg_write = '0;
  logic [31:0] data_write = '0;
  logic [31:0] src1, src2;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [0:31];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  id_reg_file DUT (
    .clk        (clk),
    .rst        (rst),
    .rs1        (rs1),
    .rs2        (rs2),
    .reg_write  (reg_write),
    .data_write (data_write),
    .src1       (src1),
    .src2       (src2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic r, input logic [4:0] rs,
                                         input logic [4:0] w, input logic [31:0] d);
    if (r)        return 32'h0;
    if (rs == 0)  return 32'h0;
    if (rs == w)  return d;
    return model[rs];
  endfunction

  // One cycle: drive at negedge, queue expected reads, sample before the
  // rising edge, then advance the model across the edge.
  task automatic step(input logic r, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] w, input logic [31:0] d, input string tag);
    logic [31:0] e;
    @(negedge clk);
    rst = r; rs1 = a; rs2 = b; reg_write = w; data_write = d;
    exp_q.push_back(exp_rd(r, a, w, d));
    exp_q.push_back(exp_rd(r, b, w, d));
    #2;
    if (exp_q.size() < 2) begin
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd2);
    end else begin
      e = exp_q.pop_front(); chk({tag, "_src1"}, src1, e);
      e = exp_q.pop_front(); chk({tag, "_src2"}, src2, e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (w != 0) begin
      model[w] = d;
    end
    #1;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s_regs%0d", tag, i), DUT.regs[i], model[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset, with write attempts that must be dropped
    step(1, 3, 4, 3, 32'h5555_AAAA, "rst_a");
    step(1, 0, 1, 1, 32'h1, "rst_b");
    chk_regs("reset");
    for (int i = 0; i < 32; i++)
      step(0, 5'(i), 5'(31 - i), 0, 32'hFFFF_FFFF, "post_rst_sweep");

    // Write/read with bypass, then read from storage
    step(0, 1, 0, 1, 32'h1, "wr_bypass");
    chk("wr_regs1", DUT.regs[1], 32'h1);
    step(0, 1, 0, 0, 32'h0, "wr_stored");

    // x0 is never written
    step(0, 0, 0, 0, 32'hDEAD_BEEF, "x0_write");
    chk("x0_regs0", DUT.regs[0], 32'h0);
    step(0, 0, 0, 0, 32'h0, "x0_read");

    // Dual read
    step(0, 0, 0, 5, 32'h1234, "dual_w5");
    step(0, 0, 0, 31, 32'hFFFF_FFFF, "dual_w31");
    step(0, 5, 31, 0, 32'h0, "dual_rd");
    step(0, 5, 5, 0, 32'h0, "dual_same");

    // Bypass beats stale storage on both ports
    step(0, 0, 0, 7, 32'd10, "byp_w7");
    step(0, 7, 7, 7, 32'd20, "byp_both");
    chk("byp_regs7", DUT.regs[7], 32'd20);

    // Reset mid-operation drops the write; everything reads 0 afterwards
    step(1, 3, 5, 3, 32'd9, "midrst");
    chk("midrst_regs3", DUT.regs[3], 32'h0);
    step(0, 1, 5, 0, 32'h0, "midrst_rd_a");
    step(0, 7, 31, 0, 32'h0, "midrst_rd_b");
    chk_regs("midrst");

    // Random traffic with occasional resets
    for (int n = 0; n < 300; n++)
      step($urandom_range(0, 39) == 0, 5'($urandom), 5'($urandom),
           5'($urandom), $urandom, "rand");
    chk_regs("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
